// File: rtl/instr_fetch_flash_ctrl.sv
//==============================================================================
// Module      : instr_fetch_flash_ctrl
// Description : Instruction fetch controller for a pair of x16 NOR flash chips
//               (upper/lower halves sharing address and control). Sequences
//               the flash RESET# release, turns a core PC request into a timed
//               CE#/OE# read cycle and returns {dq_upper, dq_lower} through a
//               valid/ready handshake.
//               Optional build macro FETCH_STATS_EN adds the stat_fetches and
//               stat_stall_cycles counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch_flash_ctrl #(
    parameter int WAIT_CYCLES     = 7,
    parameter int RST_HOLD_CYCLES = 4,
    parameter int ADDR_W          = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_ack,
    output logic              instr_valid,
    output logic [31:0]       instr,
    input  logic              instr_ready,
    output logic              fetch_err,
    input  logic              flush,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_reset_n,
    output logic              flash_byte_n,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic [15:0]       dq_upper,
    input  logic [15:0]       dq_lower
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetches,
    output logic [31:0]       stat_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Both timing parameters fit in 4 bits (legal range 1..15).
    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] c_rst_last  = 4'(RST_HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                frst_n_q, frst_n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;

    logic                w_aligned;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                unused_pc_bits;

    assign w_aligned  = (fetch_pc[1:0] == 2'b00);
    // Word address of the 32-bit instruction; bit 0 selects nothing in x16 mode.
    assign w_req_addr = {fetch_pc[ADDR_W:2], 1'b0};
    assign unused_pc_bits = ^{fetch_pc[31:ADDR_W+1]};

    // Next-state, flash control and handshake decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        frst_n_d  = frst_n_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        fetch_ack = 1'b0;
        fetch_err = 1'b0;

        if (state_q == S_INIT) begin
            // Flash RESET# release sequencing; requests are ignored here.
            if (cnt_q == c_rst_last) begin
                frst_n_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_IDLE;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (flush) begin
            // Abort: close the flash cycle, drop any held instruction.
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_req) begin
                        if (w_aligned) begin
                            fetch_ack = 1'b1;
                            addr_d    = w_req_addr;
                            ce_n_d    = 1'b0;
                            oe_n_d    = 1'b0;
                            cnt_d     = c_wait_load;
                            state_d   = S_WAIT;
                        end else begin
                            fetch_err = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        instr_d = {dq_upper, dq_lower};
                        valid_d = 1'b1;
                        ce_n_d  = 1'b1;
                        oe_n_d  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    // CE#/OE# are already high here, so a back-to-back accept
                    // still leaves the required output-disable gap.
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                        if (fetch_req && w_aligned) begin
                            fetch_ack = 1'b1;
                            addr_d    = w_req_addr;
                            ce_n_d    = 1'b0;
                            oe_n_d    = 1'b0;
                            cnt_d     = c_wait_load;
                            state_d   = S_WAIT;
                        end else if (fetch_req) begin
                            fetch_err = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Handshake pulses are quiet while the block is held in reset.
        if (!rst_n) begin
            fetch_ack = 1'b0;
            fetch_err = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            frst_n_q <= 1'b0;
            addr_q   <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            frst_n_q <= frst_n_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    assign flash_ce_n    = ce_n_q;
    assign flash_oe_n    = oe_n_q;
    assign flash_we_n    = 1'b1;
    assign flash_byte_n  = 1'b1;
    assign flash_reset_n = frst_n_q;
    assign flash_addr    = addr_q;
    assign instr         = instr_q;
    assign instr_valid   = valid_q;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetches_q, stat_fetches_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Activity counters; both wrap naturally at 2^32.
    always_comb begin
        stat_fetches_d = stat_fetches_q;
        stat_stall_d   = stat_stall_q;
        if (fetch_ack) begin
            stat_fetches_d = stat_fetches_q + 32'd1;
        end
        if (((state_q == S_WAIT) || (state_q == S_HOLD)) && !valid_q) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_fetches_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_fetches_q <= stat_fetches_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_fetches      = stat_fetches_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/instr_fetch_flash_ctrl.md
Name: instr_fetch_flash_ctrl

Overview:
- Clocked fetch controller that sits directly upstream of the two 16-bit instruction flash devices (upper-half and lower-half chips sharing address and control).
- Accepts a PC fetch request from the core and drives flash CE#/OE#/WE#/RESET#/BYTE#/A.
- Waits the programmed access time, captures both DQ buses, and returns one 32-bit instruction with a valid/ready handshake.
- Also sequences the flash RESET# release after system reset.

Parameters:
- WAIT_CYCLES, 7, clock cycles from CE#/OE# low to DQ sample (tACC at 100 MHz); legal range 1..15.
- RST_HOLD_CYCLES, 4, cycles flash_reset_n is held low after rst_n deasserts; legal range 1..15.
- ADDR_W, 19, flash address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- fetch_req  in  1  core requests a fetch at fetch_pc.
- fetch_pc  in  32  byte address of the instruction.
- fetch_ack  out  1  one-cycle pulse when the request is accepted.
- instr_valid  out  1  instr holds a complete instruction.
- instr  out  32  {upper_dq, lower_dq}.
- instr_ready  in  1  consumer takes instr this cycle.
- fetch_err  out  1  one-cycle pulse on a misaligned request.
- flush  in  1  abort any access in flight and drop the held instruction.
- flash_ce_n  out  1  chip enable, shared by both chips.
- flash_oe_n  out  1  output enable, shared.
- flash_we_n  out  1  write enable; constant 1.
- flash_reset_n  out  1  flash hardware reset.
- flash_byte_n  out  1  word-mode select; constant 1 (x16).
- flash_addr  out  ADDR_W  address; flash_addr[18:1] = fetch_pc[19:2], flash_addr[0] = 0.
- dq_upper  in  16  upper chip DQ, becomes instr[31:16].
- dq_lower  in  16  lower chip DQ, becomes instr[15:0].

Behaviour:
- Clock and reset:
  - Single clock; all state is updated on the rising clk edge.
  - rst_n is sampled synchronously: when low at an edge, all state resets.
- Reset values: state = INIT, flash_ce_n = 1, flash_oe_n = 1, flash_reset_n = 0, flash_addr = 0, instr = 0, instr_valid = 0, fetch_ack = 0, fetch_err = 0, counter = 0.
- INIT:
  - Hold flash_reset_n = 0 for RST_HOLD_CYCLES cycles after rst_n goes high, then set it to 1 and go to IDLE.
  - fetch_req is ignored during INIT.
- IDLE, on fetch_req = 1:
  - If fetch_pc[1:0] != 0: pulse fetch_err for one cycle, no fetch_ack, stay in IDLE.
  - Otherwise: pulse fetch_ack, latch flash_addr, drive flash_ce_n = 0 and flash_oe_n = 0, load the counter with WAIT_CYCLES-1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter = 0, register {dq_upper, dq_lower} into instr, set instr_valid = 1, deassert flash_ce_n and flash_oe_n, go to HOLD.
- Latency: instr_valid rises exactly WAIT_CYCLES+1 cycles after the fetch_ack cycle.
- HOLD:
  - instr and instr_valid are stable until instr_ready = 1.
  - On an edge with instr_ready = 1: clear instr_valid. If fetch_req is also 1 that cycle with an aligned PC, accept it immediately (back-to-back, fetch_ack pulses, go to WAIT); otherwise go to IDLE.
  - fetch_req is not accepted in HOLD while instr_ready = 0.
- flush (priority over everything except rst_n, in any state except INIT):
  - Next cycle: flash_ce_n = 1, flash_oe_n = 1, instr_valid = 0, state = IDLE, no capture.
  - A fetch_req in the same cycle as flush is ignored.
- Flash RESET# is never re-asserted outside rst_n.
- Between consecutive accesses, CE# and OE# are high for at least one cycle (output-disable time).
- Undriven/Z DQ bits are captured as-is; no checking.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, adds two outputs:
  - stat_fetches [31:0]: increments on each fetch_ack.
  - stat_stall_cycles [31:0]: increments on each cycle in WAIT or HOLD with instr_valid = 0.
  - Both clear on rst_n and wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release with RST_HOLD_CYCLES = 4 -> flash_reset_n low for exactly 4 cycles after rst_n rises; fetch_req = 1 held throughout produces fetch_ack only after INIT ends.
- fetch_pc = 0x0000_0008 with dq_upper = 16'h0050, dq_lower = 16'h0093 -> flash_addr = 19'h00004, CE#/OE# low for 7 cycles, instr = 32'h0050_0093 with instr_valid 8 cycles after fetch_ack.
- instr_ready held 0 for 5 cycles after valid -> instr stable and no new fetch_ack; instr_ready = 1 together with fetch_req at pc 0x0C -> back-to-back fetch, flash_addr = 19'h00006.
- fetch_pc = 0x0000_0006 -> fetch_err single pulse, no fetch_ack, CE# stays high.
- flush asserted on the 3rd WAIT cycle -> CE#/OE# high next cycle, instr_valid never rises, next fetch behaves normally.
- With FETCH_STATS_EN defined, 3 fetches with instr_ready tied high -> stat_fetches = 3, stat_stall_cycles = 21.
